// File: rtl/pixel_map_pkg.sv
// pixel_map_pkg: mode encodings and counter width shared by the pixel mapper.
package pixel_map_pkg;
  typedef enum logic {MODE_CLAMP = 1'b0, MODE_HOLD = 1'b1} mode_e;
  localparam int CNT_W = 16;
endpackage

// File: rtl/pixel_map_saturate_axis_saturate.sv
// axis_saturate: range-checks one shifted coordinate and picks clamp, hold or pass-through.
module axis_saturate #(
  parameter int V_W = 18,
  parameter int O_W = 10,
  parameter int MAX = 639
) (
  input  logic signed [V_W-1:0] v,
  input  logic                  hold,
  input  logic [O_W-1:0]        prev,
  output logic                  lo,
  output logic                  hi,
  output logic [O_W-1:0]        nxt
);
  always_comb begin
    lo  = v[V_W-1];
    hi  = !lo && (v > V_W'(MAX));
    nxt = lo ? (hold ? prev : '0) : hi ? (hold ? prev : O_W'(MAX)) : v[O_W-1:0];
  end
endmodule

// File: rtl/pixel_map_saturate.sv
// pixel_map_saturate: two-stage scale/offset then per-axis saturation of signed coordinates to pixels.
module pixel_map_saturate
  import pixel_map_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int SHIFT    = 0,
  parameter int X_OFFSET = 0,
  parameter int Y_OFFSET = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_x,
  input  logic [IN_W-1:0]  in_y,
  input  logic             mode,
  input  logic             clear_count,
  output logic             out_valid,
  output logic [X_W-1:0]   pixel_x,
  output logic [Y_W-1:0]   pixel_y,
  output logic             sat_x_lo,
  output logic             sat_x_hi,
  output logic             sat_y_lo,
  output logic             sat_y_hi,
  output logic [CNT_W-1:0] sat_count
);
  localparam int V_W = IN_W + 2;
  logic signed [V_W-1:0] vx_d, vy_d, vx_q, vy_q;
  logic                  s1_valid, s1_mode;
  logic                  x_lo, x_hi, y_lo, y_hi;
  logic [X_W-1:0]        x_nxt;
  logic [Y_W-1:0]        y_nxt;
  // two guard bits keep the offset add from wrapping for any in-range input/offset
  assign vx_d = (V_W'(signed'(in_x)) >>> SHIFT) + V_W'(X_OFFSET);
  assign vy_d = (V_W'(signed'(in_y)) >>> SHIFT) + V_W'(Y_OFFSET);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      vx_q     <= '0;
      vy_q     <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_mode  <= mode;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
    end
  axis_saturate #(.V_W(V_W), .O_W(X_W), .MAX(X_MAX)) u_x (
    .v(vx_q), .hold(s1_mode == MODE_HOLD), .prev(pixel_x), .lo(x_lo), .hi(x_hi), .nxt(x_nxt)
  );
  axis_saturate #(.V_W(V_W), .O_W(Y_W), .MAX(Y_MAX)) u_y (
    .v(vy_q), .hold(s1_mode == MODE_HOLD), .prev(pixel_y), .lo(y_lo), .hi(y_hi), .nxt(y_nxt)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_valid <= 1'b0;
      pixel_x   <= '0;
      pixel_y   <= '0;
      sat_x_lo  <= 1'b0;
      sat_x_hi  <= 1'b0;
      sat_y_lo  <= 1'b0;
      sat_y_hi  <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        pixel_x  <= x_nxt;
        pixel_y  <= y_nxt;
        sat_x_lo <= x_lo;
        sat_x_hi <= x_hi;
        sat_y_lo <= y_lo;
        sat_y_hi <= y_hi;
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) sat_count <= '0;
    else if (clear_count) sat_count <= '0;
    else if (s1_valid && (x_lo || x_hi || y_lo || y_hi) && !(&sat_count)) sat_count <= sat_count + 1'b1;
endmodule

// File: tb/tb_pixel_map_saturate.sv
// tb_pixel_map_saturate: directed vectors against default and shifted/offset instances.
module tb_pixel_map_saturate;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, mode = 1'b0, clear_count = 1'b0;
  logic [15:0] in_x = '0, in_y = '0, in_x2 = '0;
  logic        out_valid, sat_x_lo, sat_x_hi, sat_y_lo, sat_y_hi;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic [15:0] sat_count;
  logic        ov2, xlo2, xhi2, ylo2, yhi2;
  logic [9:0]  px2;
  logic [8:0]  py2;
  logic [15:0] cnt2;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  pixel_map_saturate dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .mode(mode),
    .clear_count(clear_count), .out_valid(out_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .sat_x_lo(sat_x_lo), .sat_x_hi(sat_x_hi), .sat_y_lo(sat_y_lo), .sat_y_hi(sat_y_hi),
    .sat_count(sat_count)
  );
  pixel_map_saturate #(.SHIFT(2), .X_OFFSET(320)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x2), .in_y(in_y), .mode(mode),
    .clear_count(clear_count), .out_valid(ov2), .pixel_x(px2), .pixel_y(py2),
    .sat_x_lo(xlo2), .sat_x_hi(xhi2), .sat_y_lo(ylo2), .sat_y_hi(yhi2), .sat_count(cnt2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  // one isolated sample; returns at the negedge where its result is visible
  task automatic run(input logic v, input logic [15:0] x, input logic [15:0] y, input logic [15:0] x2, input logic m);
    @(negedge clk);
    in_valid = v; in_x = x; in_y = y; in_x2 = x2; mode = m;
    @(negedge clk);
    in_valid = 1'b0; mode = 1'b0;
    chk("lat", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
  endtask
  task automatic flags(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, sat_x_lo, sat_x_hi, sat_y_lo, sat_y_hi}, {28'd0, exp});
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ov", {31'd0, out_valid}, 0);
    chk("rst_px", {22'd0, pixel_x}, 0);
    chk("rst_py", {23'd0, pixel_y}, 0);
    chk("rst_cnt", {16'd0, sat_count}, 0);
    flags("rst_flags", 4'b0000);
    reset = 1'b0;
    run(1, 16'h00F9, 16'h0000, 16'h0000, 0);
    chk("v1_ov", {31'd0, out_valid}, 1); chk("v1_px", {22'd0, pixel_x}, 249);
    chk("v1_py", {23'd0, pixel_y}, 0); flags("v1_fl", 4'b0000); chk("v1_cnt", {16'd0, sat_count}, 0);
    run(1, 16'd5, 16'hFFFF, 16'h0000, 0);
    chk("ylo_px", {22'd0, pixel_x}, 5); chk("ylo_py", {23'd0, pixel_y}, 0);
    flags("ylo_fl", 4'b0010); chk("ylo_cnt", {16'd0, sat_count}, 1);
    run(1, 16'hFEC0, 16'd250, 16'h0000, 0);
    chk("xlo_px", {22'd0, pixel_x}, 0); chk("xlo_py", {23'd0, pixel_y}, 250);
    flags("xlo_fl", 4'b1000); chk("xlo_cnt", {16'd0, sat_count}, 2);
    run(1, 16'd249, 16'd0, 16'h0000, 0);
    run(1, 16'd1000, 16'd100, 16'h0000, 1);
    chk("hold_px", {22'd0, pixel_x}, 249); chk("hold_py", {23'd0, pixel_y}, 100);
    flags("hold_fl", 4'b0100); chk("hold_cnt", {16'd0, sat_count}, 3);
    run(1, 16'd10, 16'd480, 16'h0000, 0);
    chk("yhi_px", {22'd0, pixel_x}, 10); chk("yhi_py", {23'd0, pixel_y}, 479);
    flags("yhi_fl", 4'b0001); chk("yhi_cnt", {16'd0, sat_count}, 4);
    run(1, 16'd20, 16'hFFFB, 16'h0000, 1);
    chk("yhold_px", {22'd0, pixel_x}, 20); chk("yhold_py", {23'd0, pixel_y}, 479);
    flags("yhold_fl", 4'b0010); chk("yhold_cnt", {16'd0, sat_count}, 5);
    run(0, 16'd300, 16'd300, 16'h0000, 0);
    chk("idle_ov", {31'd0, out_valid}, 0); chk("idle_px", {22'd0, pixel_x}, 20);
    flags("idle_fl", 4'b0010); chk("idle_cnt", {16'd0, sat_count}, 5);
    // back-to-back: hold sample then clamp sample, live mode held at 1 afterwards
    @(negedge clk); in_valid = 1; in_x = 16'd700; in_y = 16'd5; mode = 1;
    @(negedge clk); in_x = 16'd700; in_y = 16'd6; mode = 0;
    @(negedge clk); in_valid = 0; mode = 1;
    chk("mA_ov", {31'd0, out_valid}, 1); chk("mA_px", {22'd0, pixel_x}, 20); chk("mA_py", {23'd0, pixel_y}, 5);
    @(negedge clk);
    chk("mB_ov", {31'd0, out_valid}, 1); chk("mB_px", {22'd0, pixel_x}, 639); chk("mB_py", {23'd0, pixel_y}, 6);
    chk("mB_cnt", {16'd0, sat_count}, 7);
    mode = 0;
    @(negedge clk); clear_count = 1;
    @(negedge clk); clear_count = 0;
    chk("clr_cnt", {16'd0, sat_count}, 0);
    in_valid = 1; in_x = 16'd1000; in_y = 16'd0;
    repeat (65534) @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    chk("cnt_fffe", {16'd0, sat_count}, 32'hFFFE);
    in_valid = 1;
    repeat (3) @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    chk("cnt_sat", {16'd0, sat_count}, 32'hFFFF);
    @(negedge clk); in_valid = 1; in_x = 16'd1000;
    @(negedge clk); in_valid = 0; clear_count = 1;
    @(negedge clk); clear_count = 0;
    chk("clrpri_ov", {31'd0, out_valid}, 1); flags("clrpri_fl", 4'b0100);
    chk("clrpri_cnt", {16'd0, sat_count}, 0);
    @(negedge clk); in_valid = 1; in_x = 16'hFFFF; in_y = 16'd0;
    @(negedge clk); in_x = 16'hFFFE;
    @(posedge clk); #1;
    chk("pre_ov", {31'd0, out_valid}, 1); chk("pre_cnt", {16'd0, sat_count}, 1);
    #1 reset = 1; in_valid = 0;
    #1;
    chk("ar_ov", {31'd0, out_valid}, 0); chk("ar_px", {22'd0, pixel_x}, 0);
    chk("ar_py", {23'd0, pixel_y}, 0); flags("ar_fl", 4'b0000); chk("ar_cnt", {16'd0, sat_count}, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_ov", {31'd0, out_valid}, 0);
    end
    run(1, 16'd100, 16'd50, 16'h7FFF, 0);
    chk("first_ov", {31'd0, out_valid}, 1); chk("first_px", {22'd0, pixel_x}, 100);
    chk("first_py", {23'd0, pixel_y}, 50); chk("first_cnt", {16'd0, sat_count}, 0);
    chk("s2hi_px", {22'd0, px2}, 639); chk("s2hi_fl", {30'd0, xlo2, xhi2}, 1);
    run(1, 16'd0, 16'd0, 16'h8000, 0);
    chk("s2lo_px", {22'd0, px2}, 0); chk("s2lo_fl", {30'd0, xlo2, xhi2}, 2);
    run(1, 16'd0, 16'd0, 16'h0400, 0);
    chk("s2in_px", {22'd0, px2}, 576); chk("s2in_fl", {30'd0, xlo2, xhi2}, 0);
    chk("s2_cnt", {16'd0, cnt2}, 2); chk("s2_ov", {31'd0, ov2}, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pixel_map_saturate.md
PIXEL_MAP_SATURATE -- requirements
Module: pixel_map_saturate

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, meaning width of signed two's-complement input coordinates.
REQ-002 The block SHALL have parameter X_W, default 10, meaning pixel_x width.
REQ-003 The block SHALL have parameter Y_W, default 9, meaning pixel_y width.
REQ-004 The block SHALL have parameter X_MAX, default 639, meaning largest legal pixel_x.
REQ-005 The block SHALL have parameter Y_MAX, default 479, meaning largest legal pixel_y.
REQ-006 The block SHALL have parameter SHIFT, default 0, meaning arithmetic right shift applied to both inputs (scale by 2^-SHIFT).
REQ-007 The block SHALL have parameters X_OFFSET and Y_OFFSET, default 0, meaning signed offsets added after the shift.
REQ-008 The block SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-009 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-010 The block SHALL have port in_valid, input, 1 bit, sample strobe.
REQ-011 The block SHALL have ports in_x and in_y, input, IN_W bits each, signed filter outputs.
REQ-012 The block SHALL have port mode, input, 1 bit: 0 = clamp, 1 = hold-on-out-of-range.
REQ-013 The block SHALL have port clear_count, input, 1 bit, synchronous clear of sat_count.
REQ-014 The block SHALL have port out_valid, output, 1 bit, result strobe.
REQ-015 The block SHALL have ports pixel_x and pixel_y, output, X_W and Y_W bits, mapped coordinates.
REQ-016 The block SHALL have ports sat_x_lo, sat_x_hi, sat_y_lo and sat_y_hi, output, 1 bit each, per-axis out-of-range flags for the current result.
REQ-017 The block SHALL have port sat_count, output, 16 bits, count of out-of-range samples.

Function
REQ-018 The block SHALL be a 2-stage pipeline: stage 1 registers v = (in >>> SHIFT) + OFFSET per axis, with mode; stage 2 compares, selects and registers outputs; latency = 2 cycles, throughput 1 sample/cycle.
REQ-019 The stage-1 intermediate SHALL be IN_W+2 bits signed, sign-extended before the add, so no overflow occurs for any input/offset within IN_W bits.
REQ-020 For each axis, v<0 SHALL set *_lo, v>MAX SHALL set *_hi, and 0<=v<=MAX SHALL leave both clear; lo and hi are never both set.
REQ-021 In mode 0, the output SHALL be 0 when lo, MAX when hi, else v truncated to the output width.
REQ-022 In mode 1, an out-of-range axis SHALL keep its previous output value; the in-range axis SHALL update independently.
REQ-023 Mode SHALL travel with its sample through the pipeline; a mode change affects only samples accepted after it.
REQ-024 out_valid SHALL equal in_valid delayed 2 cycles; when a slot is invalid, pixel_x, pixel_y and flags SHALL hold their previous values.
REQ-025 sat_count SHALL increment by 1 on each valid stage-2 result with any flag set, SHALL saturate at 16'hFFFF, and SHALL be cleared by clear_count, with clear taking priority over a simultaneous increment.

Reset
REQ-026 Asserting reset SHALL immediately clear all pipeline registers and valids, set pixel_x=0, pixel_y=0, all flags 0, out_valid 0 and sat_count 0; samples in flight are discarded.
REQ-027 The first valid sample accepted after reset deasserts SHALL produce out_valid exactly 2 cycles later.

Structure
REQ-028 The mode encodings (MODE_CLAMP=0, MODE_HOLD=1) and the sat_count width constant (16) SHALL live in a shared package, pixel_map_pkg.
REQ-029 The per-axis compare/select SHALL be one sub-module, axis_saturate, parametrised by width and MAX, and instantiated twice.

Verification
REQ-030 With default parameters, mode 0, in_x=16'h00F9, in_y=0 valid -> 2 cycles later out_valid=1, pixel_x=249, pixel_y=0, flags 0, sat_count unchanged.
REQ-031 With in_y=16'hFFFF, mode 0 -> pixel_y=0, sat_y_lo=1, sat_count+1; with in_x=16'hFEC0, in_y=250 -> pixel_x=0, pixel_y=250, sat_x_lo=1.
REQ-032 With previous pixel_x=249, mode 1, in_x=1000, in_y=100 -> pixel_x=249, pixel_y=100, sat_x_hi=1.
REQ-033 With SHIFT=2, X_OFFSET=320, in_x=16'h7FFF -> pixel_x=639, sat_x_hi=1; in_x=16'h8000 -> pixel_x=0, sat_x_lo=1 (no wrap).
REQ-034 Forcing sat_count to 16'hFFFF with further out-of-range samples -> it stays at 16'hFFFF; clear_count asserted together with an out-of-range result -> sat_count=0.
REQ-035 Asserting reset with two valid samples in flight -> outputs and sat_count go to 0 immediately and no out_valid appears for those samples.
